// File: rtl/spi_display_cmd_ctrl_if.sv
// SPI pins plus register-file request/read-back signals of the display command sequencer.
// The slave modport is the sequencer's view; master is the SPI master / register-file side.
interface spi_display_cmd_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              spi_ss_i;
  logic              spi_mosi_i;
  logic              spi_miso_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              wr_toggle_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              clr_toggle_o;
  logic [7:0]        err_count_o;
  logic              busy_o;

  modport slave (
    input  spi_ss_i, spi_mosi_i, rd_data_i,
    output spi_miso_o, rd_addr_o, wr_toggle_o, wr_addr_o, wr_data_o,
           clr_toggle_o, err_count_o, busy_o
  );

  modport master (
    output spi_ss_i, spi_mosi_i, rd_data_i,
    input  spi_miso_o, rd_addr_o, wr_toggle_o, wr_addr_o, wr_data_o,
           clr_toggle_o, err_count_o, busy_o
  );
endinterface

// File: rtl/spi_display_cmd_ctrl.sv
// SPI-clocked command sequencer for the display register file: frames MOSI bytes,
// decodes write/burst/read/clear headers and emits toggle-event register requests.
module spi_display_cmd_ctrl #(
  parameter int NUM_REGS = 10,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input logic                   spi_sclk_i,
  input logic                   rst_low_i,
  spi_display_cmd_ctrl_if.slave bus
);
  localparam int                CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]        CMD_WRITE = 4'h1;
  localparam logic [3:0]        CMD_READ  = 4'h2;
  localparam logic [3:0]        CMD_BURST = 4'h3;
  localparam logic [3:0]        CMD_CLEAR = 4'h4;

  typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-2:0] r_shift;
  logic [DATA_W-1:0] r_miso_sh;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_wr_pend, w_wr_pend_nxt;
  logic              r_rd_pend, w_rd_pend_nxt;
  logic              r_wr_tog, r_clr_tog;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [7:0]        r_err_cnt;

  logic              w_ss, w_byte_done, w_addr_ok;
  logic [DATA_W-1:0] w_byte;
  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_hdr_addr;
  logic              w_do_wr, w_do_clr, w_do_err, w_rd_load, w_rd_addr_ld;

  assign w_ss        = bus.spi_ss_i;
  assign w_byte      = {r_shift, bus.spi_mosi_i};
  assign w_byte_done = (r_bit_cnt == LAST_BIT);
  assign w_cmd       = w_byte[DATA_W-1 -: 4];
  assign w_hdr_addr  = w_byte[ADDR_W-1:0];
  assign w_addr_ok   = (w_hdr_addr <= LAST_REG);

  // SS high holds the frame logic cleared, so w_byte_done can only fire inside a frame.
  always_ff @(posedge spi_sclk_i or negedge rst_low_i or posedge w_ss) begin
    if (!rst_low_i) begin
      r_state <= ST_HDR;
    end else if (w_ss) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_wr_pend_nxt = r_wr_pend;
    w_rd_pend_nxt = r_rd_pend;
    w_do_wr       = 1'b0;
    w_do_clr      = 1'b0;
    w_do_err      = 1'b0;
    w_rd_load     = 1'b0;
    w_rd_addr_ld  = 1'b0;
    if (w_byte_done) begin
      case (r_state)
        ST_HDR: begin
          w_wr_pend_nxt = 1'b0;
          w_rd_pend_nxt = 1'b0;
          w_state_nxt   = ST_DATA;
          case (w_cmd)
            CMD_WRITE, CMD_BURST, CMD_READ: begin
              if (!w_addr_ok) begin
                w_do_err    = 1'b1;
                w_state_nxt = ST_HDR;
              end else if (w_cmd == CMD_WRITE) begin
                w_ptr_nxt     = w_hdr_addr;
                w_wr_pend_nxt = 1'b1;
              end else if (w_cmd == CMD_BURST) begin
                w_ptr_nxt   = w_hdr_addr;
                w_state_nxt = ST_BURST;
              end else begin
                w_rd_addr_ld  = 1'b1;
                w_rd_pend_nxt = 1'b1;
              end
            end
            CMD_CLEAR: w_do_clr = 1'b1;
            // Unknown commands still swallow a second byte to keep 16-bit alignment.
            default:   w_do_err = 1'b1;
          endcase
        end
        ST_DATA: begin
          w_do_wr       = r_wr_pend;
          w_rd_load     = r_rd_pend;
          w_wr_pend_nxt = 1'b0;
          w_rd_pend_nxt = 1'b0;
          w_state_nxt   = ST_HDR;
        end
        ST_BURST: begin
          w_do_wr   = 1'b1;
          w_ptr_nxt = (r_ptr == LAST_REG) ? '0 : r_ptr + 1'b1;
        end
        default: w_state_nxt = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge spi_sclk_i or negedge rst_low_i or posedge w_ss) begin
    if (!rst_low_i) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_miso_sh <= '1;
    end else if (w_ss) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_miso_sh <= '1;
    end else begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      r_shift   <= w_byte[DATA_W-2:0];
      r_ptr     <= w_ptr_nxt;
      r_wr_pend <= w_wr_pend_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_miso_sh <= w_rd_load ? bus.rd_data_i : {r_miso_sh[DATA_W-2:0], 1'b1};
    end
  end

  // Request outputs survive SS; only reset clears them.
  always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      r_wr_tog  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_clr_tog <= 1'b0;
      r_err_cnt <= '0;
      r_rd_addr <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_tog  <= ~r_wr_tog;
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
      if (w_do_clr) r_clr_tog <= ~r_clr_tog;
      if (w_do_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_rd_addr_ld) r_rd_addr <= w_hdr_addr;
    end
  end

  assign bus.spi_miso_o   = r_miso_sh[DATA_W-1];
  assign bus.rd_addr_o    = r_rd_addr;
  assign bus.wr_toggle_o  = r_wr_tog;
  assign bus.wr_addr_o    = r_wr_addr;
  assign bus.wr_data_o    = r_wr_data;
  assign bus.clr_toggle_o = r_clr_tog;
  assign bus.err_count_o  = r_err_cnt;
  assign bus.busy_o       = |r_bit_cnt;
endmodule

// File: tb/tb_spi_display_cmd_ctrl.sv
// Bench for spi_display_cmd_ctrl: directed and random SPI sessions checked per edge
// against a byte-level command interpreter model.
module tb_spi_display_cmd_ctrl;
  localparam int NREG = 10;
  localparam int MAXE = 136;

  logic sclk = 1'b0;
  logic rst_n;
  always #5 sclk = ~sclk;

  spi_display_cmd_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus();

  spi_display_cmd_ctrl #(.NUM_REGS(NREG), .ADDR_W(4), .DATA_W(8)) dut (
    .spi_sclk_i (sclk),
    .rst_low_i  (rst_n),
    .bus        (bus)
  );

  logic [7:0] regval [16];
  assign bus.rd_data_i = regval[bus.rd_addr_o];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the register-file side should have observed so far.
  logic       m_tog, m_clr;
  logic [3:0] m_wa, m_rda;
  logic [7:0] m_wd, m_err;

  logic [7:0] sess [16];
  logic [7:0] tail;
  logic       e_tog  [MAXE];
  logic       e_clr  [MAXE];
  logic       e_miso [MAXE];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tog = 1'b0; m_clr = 1'b0; m_wa = '0; m_rda = '0; m_wd = '0; m_err = '0;
  endtask

  task automatic bump_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic model_write(input int a, input logic [7:0] d, input int bi, input int total);
    m_tog = ~m_tog;
    m_wa  = 4'(a);
    m_wd  = d;
    for (int j = 8*bi + 7; j < total; j++) e_tog[j] = m_tog;
  endtask

  // Interprets one SS-low session byte by byte; only complete bytes count.
  task automatic model_session(input int nb, input int total);
    int i, cmd, a;
    for (int j = 0; j < total; j++) begin
      e_tog[j] = m_tog; e_clr[j] = m_clr; e_miso[j] = 1'b1;
    end
    i = 0;
    while (i < nb) begin
      cmd = int'(sess[i][7:4]);
      a   = int'(sess[i][3:0]);
      if ((cmd == 1 || cmd == 2 || cmd == 3) && a >= NREG) begin
        bump_err();
        i = i + 1;
      end else begin
        case (cmd)
          1: begin
            if (i + 1 < nb) model_write(a, sess[i+1], i + 1, total);
            i = i + 2;
          end
          3: begin
            for (int j = i + 1; j < nb; j++) model_write((a + j - i - 1) % NREG, sess[j], j, total);
            i = nb;
          end
          2: begin
            m_rda = 4'(a);
            if (i + 1 < nb)
              for (int m = 0; m < 8; m++)
                if (8*(i+1) + 7 + m < total) e_miso[8*(i+1) + 7 + m] = regval[a][7-m];
            i = i + 2;
          end
          4: begin
            m_clr = ~m_clr;
            for (int j = 8*i + 7; j < total; j++) e_clr[j] = m_clr;
            i = i + 2;
          end
          default: begin
            bump_err();
            i = i + 2;
          end
        endcase
      end
    end
  endtask

  task automatic check_idle_outputs();
    check_val("busy_idle",  32'(bus.busy_o),       32'd0);
    check_val("miso_idle",  32'(bus.spi_miso_o),   32'd1);
    check_val("wr_toggle",  32'(bus.wr_toggle_o),  32'(m_tog));
    check_val("wr_addr",    32'(bus.wr_addr_o),    32'(m_wa));
    check_val("wr_data",    32'(bus.wr_data_o),    32'(m_wd));
    check_val("clr_toggle", 32'(bus.clr_toggle_o), 32'(m_clr));
    check_val("err_count",  32'(bus.err_count_o),  32'(m_err));
    check_val("rd_addr",    32'(bus.rd_addr_o),    32'(m_rda));
  endtask

  // Sends nb bytes from sess plus tb leading bits of tail, then raises SS.
  task automatic run_session(input int nb, input int tb);
    int total;
    total = 8*nb + tb;
    model_session(nb, total);
    for (int k = 0; k < total; k++) begin
      @(negedge sclk);
      bus.spi_ss_i   = 1'b0;
      bus.spi_mosi_i = (k < 8*nb) ? sess[k/8][7 - (k%8)] : tail[7 - (k%8)];
      @(posedge sclk);
      #1;
      check_val("wr_toggle_edge", 32'(bus.wr_toggle_o),  32'(e_tog[k]));
      check_val("clr_edge",       32'(bus.clr_toggle_o), 32'(e_clr[k]));
      check_val("miso_edge",      32'(bus.spi_miso_o),   32'(e_miso[k]));
      check_val("busy_edge",      32'(bus.busy_o),       32'(((k + 1) % 8) != 0));
    end
    @(negedge sclk);
    bus.spi_ss_i = 1'b1;
    #1;
    check_idle_outputs();
    repeat (2) @(negedge sclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.spi_ss_i   = 1'b1;
    bus.spi_mosi_i = 1'b0;
    tail           = '0;
    for (int i = 0; i < 16; i++) regval[i] = 8'($urandom);
    regval[5] = 8'h5C;
    model_reset();
    repeat (3) @(negedge sclk);
    #1;
    check_idle_outputs();
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);

    sess[0] = 8'h13; sess[1] = 8'hA5;
    run_session(2, 0);
    check_val("write_addr_3",  32'(bus.wr_addr_o), 32'd3);
    check_val("write_data_A5", 32'(bus.wr_data_o), 32'hA5);

    sess[0] = 8'h38; sess[1] = 8'h11; sess[2] = 8'h22; sess[3] = 8'h33;
    run_session(4, 0);
    check_val("burst_wrap_addr", 32'(bus.wr_addr_o), 32'd0);
    check_val("burst_wrap_data", 32'(bus.wr_data_o), 32'h33);

    sess[0] = 8'h25; sess[1] = 8'h00; sess[2] = 8'h00;
    run_session(3, 0);
    check_val("read_addr_5", 32'(bus.rd_addr_o), 32'd5);

    sess[0] = 8'h1C; sess[1] = 8'h00;
    run_session(2, 0);
    sess[0] = 8'h70; sess[1] = 8'h00;
    run_session(2, 0);

    tail = 8'h13;
    run_session(0, 5);
    sess[0] = 8'h17; sess[1] = 8'h01;
    run_session(2, 0);
    check_val("after_abort_addr", 32'(bus.wr_addr_o), 32'd7);
    check_val("after_abort_data", 32'(bus.wr_data_o), 32'h01);

    sess[0] = 8'h40; sess[1] = 8'h00;
    run_session(2, 0);

    for (int s = 0; s < 130; s++) begin
      sess[0] = 8'hF0; sess[1] = 8'h00; sess[2] = 8'hF0; sess[3] = 8'h00;
      run_session(4, 0);
    end
    check_val("err_saturated", 32'(bus.err_count_o), 32'hFF);

    // Reset asserted in the middle of a burst frame.
    sess[0] = 8'h32; sess[1] = 8'hAA; sess[2] = 8'hBB;
    for (int k = 0; k < 20; k++) begin
      @(negedge sclk);
      bus.spi_ss_i   = 1'b0;
      bus.spi_mosi_i = sess[k/8][7 - (k%8)];
    end
    @(negedge sclk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_outputs();
    @(negedge sclk);
    bus.spi_ss_i = 1'b1;
    rst_n        = 1'b1;
    @(negedge sclk);

    for (int s = 0; s < 150; s++) begin
      int nb, tb;
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        sess[b] = 8'($urandom);
        if ($urandom_range(0, 1) == 1)
          sess[b] = {4'($urandom_range(1, 4)), 4'($urandom_range(0, 11))};
      end
      tb   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      tail = 8'($urandom);
      run_session(nb, tb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
